board_io_ctrl: RTL and testbench

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 123 ++++++++++++
 tb/tb_board_io_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: per-channel synchroniser, debouncer, edge detector and
// sticky interrupt-pending logic for raw board inputs (switches, buttons).
// Optional feature: define BOARD_IO_EVCNT_EN to add a saturating 16-bit
// counter of enabled interrupt events (cnt_clr_i / evcnt_o).
module board_io_ctrl #(
  parameter int NUM_CH      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 80000,
  parameter int IRQ_RISE    = 1,
  parameter int IRQ_FALL    = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [NUM_CH-1:0] in_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic [NUM_CH-1:0] clr_i,
`ifdef BOARD_IO_EVCNT_EN
  input  logic              cnt_clr_i,
  output logic [15:0]       evcnt_o,
`endif
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] edge_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic              irq_o
);

  // Counter is wide enough to hold DB_CYCLES; it fires one step before
  // it would reach DB_CYCLES, so it never actually stores that value.
  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_level;
  logic [NUM_CH-1:0] r_edge;
  logic [NUM_CH-1:0] r_pend;
  logic              r_irq;

  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_fire;
  logic [NUM_CH-1:0] w_set;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain: only the last stage feeds the debouncer.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Decide per channel whether the debounced level flips this clock, and
  // whether that flip's direction qualifies for setting pending.
  always_comb begin
    w_fire = '0;
    w_set  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_fire[i] = (w_sync[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
      w_set[i]  = w_fire[i] &&
                  (((IRQ_RISE != 0) &&  w_sync[i]) ||
                   ((IRQ_FALL != 0) && !w_sync[i]));
    end
  end

  // Stability counters: run while sync disagrees with level, clear otherwise
  // and on the clock the new level is accepted.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((w_sync[i] == r_level[i]) || w_fire[i]) r_cnt[i] <= '0;
        else                                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level, one-clock edge pulse, sticky pending (set wins over
  // clear) and the registered interrupt request.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_level <= '0;
      r_edge  <= '0;
      r_pend  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_level <= r_level ^ w_fire;
      r_edge  <= w_fire;
      r_pend  <= (r_pend & ~clr_i) | w_set;
      r_irq   <= |(r_pend & en_i);
    end
  end

  assign level_o = r_level;
  assign edge_o  = r_edge;
  assign pend_o  = r_pend;
  assign irq_o   = r_irq;

`ifdef BOARD_IO_EVCNT_EN
  logic [15:0] r_evcnt;
  logic        w_evt;

  // One count per clock in which any enabled channel takes a qualifying edge.
  assign w_evt = |(w_set & en_i);

  // Saturating event counter; clear has priority over increment.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_evcnt <= '0;
    end else if (cnt_clr_i) begin
      r_evcnt <= '0;
    end else if (w_evt && (r_evcnt != 16'hFFFF)) begin
      r_evcnt <= r_evcnt + 16'd1;
    end
  end

  assign evcnt_o = r_evcnt;
`endif

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed scoreboard bench for board_io_ctrl with NUM_CH=4, SYNC_STAGES=2,
// DB_CYCLES=4, IRQ_RISE=1, IRQ_FALL=0. The evcnt section is compiled only
// when BOARD_IO_EVCNT_EN is defined.
module tb_board_io_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] in_v, en_v, clr_v;
  logic [3:0] level, edge_w, pend;
  logic       irq;
`ifdef BOARD_IO_EVCNT_EN
  logic        cnt_clr;
  logic [15:0] evcnt;
`endif

  always #5 clk = ~clk;

  board_io_ctrl #(
    .NUM_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .IRQ_RISE(1), .IRQ_FALL(0)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .in_i     (in_v),
    .en_i     (en_v),
    .clr_i    (clr_v),
`ifdef BOARD_IO_EVCNT_EN
    .cnt_clr_i(cnt_clr),
    .evcnt_o  (evcnt),
`endif
    .level_o  (level),
    .edge_o   (edge_w),
    .pend_o   (pend),
    .irq_o    (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until edge_o[ch] pulses, bounded; n is the number of clocks taken.
  task automatic wait_edge(input int ch, input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!edge_w[ch] && n < maxc);
  endtask

  int n;
  logic seen;

  initial begin
    arst_n = 1'b0;
    in_v = '0; en_v = '0; clr_v = '0;
`ifdef BOARD_IO_EVCNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    push("rst_level", 0); pop_chk(level);
    push("rst_edge",  0); pop_chk(edge_w);
    push("rst_pend",  0); pop_chk(pend);
    push("rst_irq",   0); pop_chk(irq);
    arst_n = 1'b1;
    tick(); tick();

    // Rising edge on ch0 with interrupt enabled
    en_v = 4'b0001;
    push("ch0_rise_latency", 6);
    in_v = 4'b0001;
    wait_edge(0, 20, n);
    pop_chk(n);
    push("ch0_rise_level", 4'b0001); pop_chk(level);
    push("ch0_rise_edge",  4'b0001); pop_chk(edge_w);
    push("ch0_rise_pend",  4'b0001); pop_chk(pend);
    push("ch0_rise_irq_early", 0);   pop_chk(irq);
    tick();
    push("ch0_rise_irq",   1);       pop_chk(irq);
    push("ch0_edge_one_clk", 0);     pop_chk(edge_w);

    // Short glitch on ch1 is rejected
    seen = 1'b0;
    in_v = 4'b0011;
    repeat (3) begin tick(); seen |= edge_w[1]; end
    in_v = 4'b0001;
    repeat (10) begin tick(); seen |= edge_w[1]; end
    push("glitch_edge", 0);       pop_chk(seen);
    push("glitch_level", 4'b0001); pop_chk(level);
    push("glitch_pend", 4'b0001);  pop_chk(pend);

    // ch2 rises, is cleared, then falls without setting pending
    in_v = 4'b0101;
    push("ch2_rise_latency", 6);
    wait_edge(2, 20, n); pop_chk(n);
    push("ch2_rise_pend", 4'b0101); pop_chk(pend);
    clr_v = 4'b0100; tick(); clr_v = 4'b0000;
    push("ch2_clr_pend", 4'b0001); pop_chk(pend);
    in_v = 4'b0001;
    push("ch2_fall_latency", 6);
    wait_edge(2, 20, n); pop_chk(n);
    push("ch2_fall_edge", 4'b0100);  pop_chk(edge_w);
    push("ch2_fall_level", 4'b0001); pop_chk(level);
    push("ch2_fall_pend", 4'b0001);  pop_chk(pend);

    // Clear of ch0 and simultaneous set/clear priority
    clr_v = 4'b0001; tick(); clr_v = 4'b0000;
    push("ch0_clr_pend", 0);     pop_chk(pend);
    push("ch0_clr_irq_lag", 1);  pop_chk(irq);
    tick();
    push("ch0_clr_irq", 0);      pop_chk(irq);
    in_v = 4'b0000;
    wait_edge(0, 20, n);
    push("ch0_fall_pend", 0);    pop_chk(pend);
    in_v = 4'b0001;
    repeat (5) tick();
    clr_v = 4'b0001;
    tick();
    push("setclr_edge", 4'b0001); pop_chk(edge_w);
    push("setclr_pend", 4'b0001); pop_chk(pend);
    tick();
    clr_v = 4'b0000;
    push("setclr_then_clr_pend", 0); pop_chk(pend);
    push("setclr_irq_lag", 1);       pop_chk(irq);
    tick();
    push("setclr_irq_drop", 0);      pop_chk(irq);

    // Simultaneous rising edges on ch1 and ch3
    in_v = 4'b1011;
    push("multi_latency", 6);
    wait_edge(1, 20, n); pop_chk(n);
    push("multi_edge",  4'b1010); pop_chk(edge_w);
    push("multi_level", 4'b1011); pop_chk(level);
    push("multi_pend",  4'b1010); pop_chk(pend);

    // Reset in the middle of a debounce window
    en_v = 4'b1111;
    in_v = 4'b1010;
    wait_edge(0, 20, n);
    push("pre_rst_irq", 1); pop_chk(irq);
    in_v = 4'b1011;
    repeat (3) tick();
    arst_n = 1'b0;
    #2;
    push("arst_level", 0); pop_chk(level);
    push("arst_pend",  0); pop_chk(pend);
    push("arst_irq",   0); pop_chk(irq);
    tick(); tick();
    arst_n = 1'b1;
    push("post_rst_latency", 6);
    wait_edge(0, 20, n); pop_chk(n);
    push("post_rst_level", 4'b1011); pop_chk(level);
    push("post_rst_pend",  4'b1011); pop_chk(pend);

`ifdef BOARD_IO_EVCNT_EN
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    push("evcnt_clr", 0); pop_chk(evcnt);
    en_v = 4'b0001;
    in_v = 4'b0010;
    wait_edge(0, 20, n);
    for (int k = 0; k < 3; k++) begin
      in_v = 4'b0011; wait_edge(0, 20, n);
      in_v = 4'b0010; wait_edge(0, 20, n);
    end
    en_v = 4'b1001;
    in_v = 4'b1011;
    wait_edge(0, 20, n);
    push("evcnt_four", 4); pop_chk(evcnt);
    in_v = 4'b0010;
    wait_edge(0, 20, n);
    @(negedge clk);
    force dut.r_evcnt = 16'hFFFF;
    #1;
    release dut.r_evcnt;
    in_v = 4'b0011;
    wait_edge(0, 20, n);
    tick();
    push("evcnt_sat", 16'hFFFF); pop_chk(evcnt);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
